// File: rtl/rst_seq_ctrl.sv
// Reset sequencing controller: releases per-domain active-low resets in index order,
// gated by a minimum gap and each domain's ready handshake, with soft-reset rerun.
module rst_seq_ctrl #(
  parameter int N_DOMAINS   = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int TIMEOUT     = 256,
  localparam int SW         = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_soft_rst_req,
  input  logic [N_DOMAINS-1:0] i_stage_ready,
  output logic [N_DOMAINS-1:0] o_rst_n,
  output logic                 o_all_ready,
  output logic                 o_soft_ack,
  output logic                 o_timeout_err,
  output logic [1:0]           o_state,
  output logic [SW-1:0]        o_stage
);

  localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [SW-1:0]    LAST_STG  = SW'(N_DOMAINS - 1);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_STAGE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
  logic [N_DOMAINS-1:0]   dom_rst_n_r, dom_rst_n_nxt_s;
  logic                   all_ready_r, all_ready_nxt_s;
  logic                   soft_ack_r, soft_ack_nxt_s;
  logic                   timeout_err_r, timeout_err_nxt_s;
  logic [SW-1:0]          stage_r, stage_nxt_s, next_idx_s;
  logic                   ready_sel_s, adv_s;

  // Next-state and next-output decode; soft request outranks sequencing.
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = cnt_r;
    dom_rst_n_nxt_s   = dom_rst_n_r;
    all_ready_nxt_s   = all_ready_r;
    soft_ack_nxt_s    = 1'b0;
    timeout_err_nxt_s = timeout_err_r;
    stage_nxt_s       = stage_r;
    next_idx_s        = stage_r + SW'(1);
    ready_sel_s       = i_stage_ready[stage_r];
    adv_s             = (cnt_r >= GAP_LAST) && (ready_sel_s || (cnt_r == TO_LAST));

    if (i_soft_rst_req) begin
      case (state_r)
        ST_HOLD: begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end
        default: begin
          state_nxt_s       = ST_HOLD;
          cnt_nxt_s         = {CNT_W{1'b0}};
          dom_rst_n_nxt_s   = {N_DOMAINS{1'b0}};
          all_ready_nxt_s   = 1'b0;
          timeout_err_nxt_s = 1'b0;
          stage_nxt_s       = {SW{1'b0}};
          soft_ack_nxt_s    = 1'b1;
        end
      endcase
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            dom_rst_n_nxt_s[0] = 1'b1;
            state_nxt_s        = ST_STAGE;
            stage_nxt_s        = {SW{1'b0}};
            cnt_nxt_s          = {CNT_W{1'b0}};
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_STAGE: begin
          if (adv_s) begin
            if (!ready_sel_s) begin
              timeout_err_nxt_s = 1'b1;
            end else begin
              timeout_err_nxt_s = timeout_err_r;
            end
            cnt_nxt_s = {CNT_W{1'b0}};
            if (stage_r < LAST_STG) begin
              dom_rst_n_nxt_s[next_idx_s] = 1'b1;
              stage_nxt_s                 = next_idx_s;
            end else begin
              state_nxt_s     = ST_DONE;
              all_ready_nxt_s = 1'b1;
            end
          end else if (cnt_r != TO_LAST) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
        end
        default: begin
          // Illegal encoding: fall back to a fully held sequence.
          state_nxt_s       = ST_HOLD;
          cnt_nxt_s         = {CNT_W{1'b0}};
          dom_rst_n_nxt_s   = {N_DOMAINS{1'b0}};
          all_ready_nxt_s   = 1'b0;
          timeout_err_nxt_s = 1'b0;
          stage_nxt_s       = {SW{1'b0}};
        end
      endcase
    end
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_HOLD;
      cnt_r         <= {CNT_W{1'b0}};
      dom_rst_n_r   <= {N_DOMAINS{1'b0}};
      all_ready_r   <= 1'b0;
      soft_ack_r    <= 1'b0;
      timeout_err_r <= 1'b0;
      stage_r       <= {SW{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      dom_rst_n_r   <= dom_rst_n_nxt_s;
      all_ready_r   <= all_ready_nxt_s;
      soft_ack_r    <= soft_ack_nxt_s;
      timeout_err_r <= timeout_err_nxt_s;
      stage_r       <= stage_nxt_s;
    end
  end

  assign o_rst_n       = dom_rst_n_r;
  assign o_all_ready   = all_ready_r;
  assign o_soft_ack    = soft_ack_r;
  assign o_timeout_err = timeout_err_r;
  assign o_state       = state_r;
  assign o_stage       = stage_r;

endmodule
